// File: rtl/smc_wr_strobe_lite.sv
// Static-memory write-timing generator: sequences SETUP -> STROBE -> HOLD for one write access
// and drives registered, glitch-free strobes into the downstream write-enable gating stage.
module smc_wr_strobe_lite #(
  parameter int unsigned BE_W     = 4,
  parameter int unsigned SETUP_W  = 2,
  parameter int unsigned STROBE_W = 4,
  parameter int unsigned HOLD_W   = 2
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic                wr_start,
  input  logic [BE_W-1:0]     wr_be,
  input  logic [SETUP_W-1:0]  cfg_ws_setup,
  input  logic [STROBE_W-1:0] cfg_ws_strobe,
  input  logic [HOLD_W-1:0]   cfg_ws_hold,
  output logic [BE_W-1:0]     n_r_we,
  output logic                n_r_wr,
  output logic                r_full,
  output logic                wr_busy,
  output logic                wr_done
);

  localparam int unsigned SH_W  = (SETUP_W > HOLD_W) ? SETUP_W : HOLD_W;
  localparam int unsigned CNT_W = (STROBE_W > SH_W) ? STROBE_W : SH_W;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [BE_W-1:0]     r_be, w_be_d;
  logic [STROBE_W-1:0] r_strobe, w_strobe_d;
  logic [HOLD_W-1:0]   r_hold, w_hold_d;

  logic [SETUP_W-1:0]  w_setup_m1;
  logic [HOLD_W-1:0]   w_hold_m1;
  logic                w_cnt_zero;

  assign w_setup_m1 = cfg_ws_setup - SETUP_W'(1);
  assign w_hold_m1  = r_hold - HOLD_W'(1);
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_be_d     = r_be;
    w_strobe_d = r_strobe;
    w_hold_d   = r_hold;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (wr_start) begin
          w_be_d     = wr_be;
          w_strobe_d = cfg_ws_strobe;
          w_hold_d   = cfg_ws_hold;
          if (cfg_ws_setup != '0) begin
            w_state_d = StSetup;
            w_cnt_d   = CNT_W'(w_setup_m1);
          end else begin
            w_state_d = StStrobe;
            w_cnt_d   = CNT_W'(cfg_ws_strobe);
          end
        end
      end
      StSetup: begin
        if (w_cnt_zero) begin
          w_state_d = StStrobe;
          w_cnt_d   = CNT_W'(r_strobe);
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StStrobe: begin
        if (w_cnt_zero) begin
          if (r_hold != '0) begin
            w_state_d = StHold;
            w_cnt_d   = CNT_W'(w_hold_m1);
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StHold: begin
        if (w_cnt_zero) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state they describe.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_be     <= '0;
      r_strobe <= '0;
      r_hold   <= '0;
      n_r_we   <= '1;
      n_r_wr   <= 1'b1;
      r_full   <= 1'b0;
      wr_busy  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_be     <= w_be_d;
      r_strobe <= w_strobe_d;
      r_hold   <= w_hold_d;
      n_r_we   <= (w_state_d == StStrobe) ? ~w_be_d : '1;
      n_r_wr   <= (w_state_d != StStrobe);
      r_full   <= (w_state_d == StStrobe);
      wr_busy  <= (w_state_d != StIdle);
      wr_done  <= (w_state_d == StIdle) && (r_state != StIdle);
    end
  end

endmodule
